// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl
//   Multiplexed 4-digit display scan controller. A prescaler steps the digit
//   index every DIV clocks. New display content is written into a shadow
//   register set and only committed to the active set at a frame boundary
//   (the end of digit 3), so a frame never shows a mix of old and new data.
//   A frame counter drives a blink phase that blanks blink-enabled digits.
//
// Ports
//   clk          in   system clock
//   rst          in   synchronous active-high reset
//   load         in   one-cycle strobe capturing the *_in payload
//   hex_in       in   four hex nibbles, digit0 = [3:0]
//   point_in     in   decimal point per digit
//   le_in        in   blank per digit (1 = blanked)
//   blink_en_in  in   blink enable per digit
//   scan         out  current digit index
//   hexs         out  active hex word
//   points       out  active decimal points
//   LEs          out  effective blank per digit (static blank or blink)
//   frame        out  one-cycle pulse after each frame boundary
//   pending      out  shadow holds data not yet committed
module disp_scan_ctrl #(
    parameter int DIV          = 50000,
    parameter int BLINK_FRAMES = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        load,
    input  logic [15:0] hex_in,
    input  logic [3:0]  point_in,
    input  logic [3:0]  le_in,
    input  logic [3:0]  blink_en_in,
    output logic [1:0]  scan,
    output logic [15:0] hexs,
    output logic [3:0]  points,
    output logic [3:0]  LEs,
    output logic        frame,
    output logic        pending
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int FW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic [1:0]    scan_q, scan_d;
    logic [FW-1:0] fcnt_q, fcnt_d;
    logic          phase_q, phase_d;

    logic [15:0]   sh_hex_q, sh_hex_d;
    logic [3:0]    sh_pt_q, sh_pt_d;
    logic [3:0]    sh_le_q, sh_le_d;
    logic [3:0]    sh_be_q, sh_be_d;
    logic          pend_q, pend_d;

    logic [15:0]   hex_q, hex_d;
    logic [3:0]    pt_q, pt_d;
    logic [3:0]    le_q, le_d;
    logic [3:0]    be_q, be_d;

    logic [3:0]    les_q, les_d;
    logic          frame_q, frame_d;

    logic          tick;
    logic          boundary;

    always_comb begin
        tick     = (cnt_q == CW'(DIV - 1));
        boundary = tick && (scan_q == 2'd3);

        cnt_d  = tick ? '0 : cnt_q + CW'(1);
        scan_d = tick ? scan_q + 2'd1 : scan_q;

        fcnt_d  = fcnt_q;
        phase_d = phase_q;
        if (boundary) begin
            if (fcnt_q == FW'(BLINK_FRAMES - 1)) begin
                fcnt_d  = '0;
                phase_d = ~phase_q;
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end

        sh_hex_d = sh_hex_q;
        sh_pt_d  = sh_pt_q;
        sh_le_d  = sh_le_q;
        sh_be_d  = sh_be_q;
        pend_d   = pend_q;
        if (load) begin
            sh_hex_d = hex_in;
            sh_pt_d  = point_in;
            sh_le_d  = le_in;
            sh_be_d  = blink_en_in;
            pend_d   = 1'b1;
        end

        hex_d = hex_q;
        pt_d  = pt_q;
        le_d  = le_q;
        be_d  = be_q;
        if (boundary) begin
            // A load landing on the boundary edge bypasses the shadow so it
            // is not held back a whole frame.
            if (load) begin
                hex_d  = hex_in;
                pt_d   = point_in;
                le_d   = le_in;
                be_d   = blink_en_in;
                pend_d = 1'b0;
            end else if (pend_q) begin
                hex_d  = sh_hex_q;
                pt_d   = sh_pt_q;
                le_d   = sh_le_q;
                be_d   = sh_be_q;
                pend_d = 1'b0;
            end
        end

        // Built from next-state values so LEs always matches the active set
        // and blink phase visible in the same cycle.
        les_d   = le_d | (be_d & {4{phase_d}});
        frame_d = boundary;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= '0;
            scan_q   <= 2'd0;
            fcnt_q   <= '0;
            phase_q  <= 1'b0;
            sh_hex_q <= 16'h0000;
            sh_pt_q  <= 4'h0;
            sh_le_q  <= 4'h0;
            sh_be_q  <= 4'h0;
            pend_q   <= 1'b0;
            hex_q    <= 16'h0000;
            pt_q     <= 4'h0;
            le_q     <= 4'hF;
            be_q     <= 4'h0;
            les_q    <= 4'hF;
            frame_q  <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            scan_q   <= scan_d;
            fcnt_q   <= fcnt_d;
            phase_q  <= phase_d;
            sh_hex_q <= sh_hex_d;
            sh_pt_q  <= sh_pt_d;
            sh_le_q  <= sh_le_d;
            sh_be_q  <= sh_be_d;
            pend_q   <= pend_d;
            hex_q    <= hex_d;
            pt_q     <= pt_d;
            le_q     <= le_d;
            be_q     <= be_d;
            les_q    <= les_d;
            frame_q  <= frame_d;
        end
    end

    assign scan    = scan_q;
    assign hexs    = hex_q;
    assign points  = pt_q;
    assign LEs     = les_q;
    assign frame   = frame_q;
    assign pending = pend_q;

endmodule

// File: tb/tb_disp_scan_ctrl.sv
module tb_disp_scan_ctrl;

    localparam int DIV   = 4;
    localparam int BF    = 2;
    localparam int FLEN  = 4 * DIV;

    logic        clk = 1'b0;
    logic        rst, load;
    logic [15:0] hex_in;
    logic [3:0]  point_in, le_in, blink_en_in;
    logic [1:0]  scan;
    logic [15:0] hexs;
    logic [3:0]  points, LEs;
    logic        frame, pending;

    disp_scan_ctrl #(.DIV(DIV), .BLINK_FRAMES(BF)) dut (
        .clk(clk), .rst(rst), .load(load), .hex_in(hex_in),
        .point_in(point_in), .le_in(le_in), .blink_en_in(blink_en_in),
        .scan(scan), .hexs(hexs), .points(points), .LEs(LEs),
        .frame(frame), .pending(pending)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %h expected %h", name, $time, act, exp);
        end
    endtask

    // Reference model: time since reset release drives everything about
    // scanning and blinking; display content tracked as shadow/active sets.
    int          m_n = 0;
    bit          m_valid = 0;
    logic [15:0] m_sh_hex, m_hex;
    logic [3:0]  m_sh_pt, m_sh_le, m_sh_be, m_pt, m_le, m_be;
    bit          m_pend;

    always @(posedge clk) begin
        if (rst) begin
            m_valid = 1;
            m_n = 0;
            m_sh_hex = 0; m_sh_pt = 0; m_sh_le = 0; m_sh_be = 0;
            m_pend = 0;
            m_hex = 0; m_pt = 0; m_le = 4'hF; m_be = 0;
        end else if (m_valid) begin
            bit bnd;
            bit old_pend;
            bnd = ((m_n + 1) % FLEN) == 0;
            old_pend = m_pend;
            if (bnd && load) begin
                m_hex = hex_in; m_pt = point_in; m_le = le_in; m_be = blink_en_in;
            end else if (bnd && old_pend) begin
                m_hex = m_sh_hex; m_pt = m_sh_pt; m_le = m_sh_le; m_be = m_sh_be;
            end
            if (load) begin
                m_sh_hex = hex_in; m_sh_pt = point_in; m_sh_le = le_in; m_sh_be = blink_en_in;
                m_pend = 1;
            end
            if (bnd) m_pend = 0;
            m_n++;
        end
    end

    function automatic logic [3:0] exp_les();
        int  frames;
        bit  ph;
        frames = m_n / FLEN;
        ph = ((frames / BF) % 2) == 1;
        return m_le | (m_be & {4{ph}});
    endfunction

    // Compare process: every cycle once the model is anchored by a reset.
    always @(negedge clk) begin
        if (m_valid) begin
            chk("scan",    32'(scan),    32'((m_n / DIV) % 4));
            chk("hexs",    32'(hexs),    32'(m_hex));
            chk("points",  32'(points),  32'(m_pt));
            chk("LEs",     32'(LEs),     32'(exp_les()));
            chk("frame",   32'(frame),   32'((m_n > 0) && (m_n % FLEN == 0)));
            chk("pending", 32'(pending), 32'(m_pend));
        end
    end

    int e;

    task automatic at_edge();
        @(posedge clk);
        #1;
        e++;
    endtask

    task automatic go_to(input int target);
        while (e < target) at_edge();
    endtask

    task automatic do_load(input logic [15:0] h, input logic [3:0] p,
                           input logic [3:0] l, input logic [3:0] b);
        load = 1; hex_in = h; point_in = p; le_in = l; blink_en_in = b;
        at_edge();
        load = 0;
    endtask

    initial begin
        rst = 1; load = 1; hex_in = 16'hFFFF; point_in = 4'hF; le_in = 4'h0; blink_en_in = 4'hF;
        e = 0;
        at_edge(); at_edge();
        chk("rst_scan",    32'(scan),    0);
        chk("rst_hexs",    32'(hexs),    32'h0000);
        chk("rst_points",  32'(points),  0);
        chk("rst_LEs",     32'(LEs),     32'hF);
        chk("rst_pending", 32'(pending), 0);
        chk("rst_frame",   32'(frame),   0);

        rst = 0; load = 0; e = 0;
        go_to(4);  chk("cad_scan4",  32'(scan), 1);
        go_to(8);  chk("cad_scan8",  32'(scan), 2);
        go_to(12); chk("cad_scan12", 32'(scan), 3);
        go_to(15); chk("cad_frame15", 32'(frame), 0);
        go_to(16); chk("cad_scan16", 32'(scan), 0);
                   chk("cad_frame16", 32'(frame), 1);
        go_to(17); chk("cad_frame17", 32'(frame), 0);

        go_to(20);
        do_load(16'h1234, 4'b0101, 4'h0, 4'h0);           // e = 21
        chk("mid_pending", 32'(pending), 1);
        chk("mid_hold",    32'(hexs), 32'h0000);
        go_to(31); chk("mid_hold31", 32'(hexs), 32'h0000);
        go_to(32);
        chk("mid_hexs",    32'(hexs), 32'h1234);
        chk("mid_points",  32'(points), 32'h5);
        chk("mid_LEs",     32'(LEs), 0);
        chk("mid_pend0",   32'(pending), 0);

        go_to(33); do_load(16'hAAAA, 4'h0, 4'h0, 4'h0);
        go_to(40); do_load(16'h5555, 4'h0, 4'h0, 4'h0);
        go_to(47); chk("lw_hold", 32'(hexs), 32'h1234);
        go_to(48); chk("lw_hexs", 32'(hexs), 32'h5555);

        go_to(63); do_load(16'hBEEF, 4'h0, 4'h0, 4'h0);  // e = 64
        chk("col_hexs",    32'(hexs), 32'hBEEF);
        chk("col_pending", 32'(pending), 0);

        go_to(65); do_load(16'hBEEF, 4'h0, 4'h0, 4'b0001);
        go_to(80);  chk("blk_80",  32'(LEs), 0);
        go_to(95);  chk("blk_95",  32'(LEs), 0);
        go_to(96);  chk("blk_96",  32'(LEs), 1);
        go_to(127); chk("blk_127", 32'(LEs), 1);
        go_to(128); chk("blk_128", 32'(LEs), 0);

        go_to(130); do_load(16'h7777, 4'h0, 4'h0, 4'h0);
        chk("mrst_pend1", 32'(pending), 1);
        rst = 1;
        at_edge();
        rst = 0;
        chk("mrst_LEs",  32'(LEs), 32'hF);
        chk("mrst_pend", 32'(pending), 0);
        chk("mrst_scan", 32'(scan), 0);
        chk("mrst_hexs", 32'(hexs), 0);
        repeat (3) at_edge();
        chk("mrst_scan3", 32'(scan), 0);
        at_edge();
        chk("mrst_scan4", 32'(scan), 1);

        for (int i = 0; i < 4000; i++) begin
            rst         = ($urandom_range(0, 599) == 0);
            load        = ($urandom_range(0, 5) == 0);
            hex_in      = 16'($urandom);
            point_in    = 4'($urandom);
            le_in       = ($urandom_range(0, 1) == 0) ? 4'h0 : 4'($urandom);
            blink_en_in = 4'($urandom);
            at_edge();
        end
        rst = 0; load = 0;
        at_edge();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
